dce_uart_rx: RTL and testbench
==============================

# dce_uart_rx

Receive front end for the DCE side of the light UART link. It deserialises 8N1 characters arriving on the transactor's `txd` wire, using the same 32-bit baud divisor the DCE already publishes as `DBR`. Received bytes are buffered in a small FIFO and presented on a valid/ready byte stream to the loopback/echo logic downstream. It drives `rts` so that the transactor holds off transmission before the buffer overflows.

## Interface
- `FIFO_DEPTH`, 4: receive buffer entries, power of two, ≥2.
- `MIN_DIV`, 4: lower clamp applied to `baud_div`.

Ports:
- `clock`  in  1  single receive clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rxd`  in  1  serial input, idle high; asynchronous to `clock`.
- `baud_div`  in  32  clock cycles per bit period; latched at start-bit detection.
- `rts`  out  1  1 = transactor may send.
- `out_valid`  out  1  FIFO non-empty.
- `out_data`  out  8  head-of-FIFO byte.
- `out_ready`  in  1  consumer accepts the head when `out_valid & out_ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: byte completed while FIFO full; byte dropped.
- `fill`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- `rxd` passes through a 2-flop synchroniser; both flops reset to 1. `rxs` is the synchroniser output.
- Effective divisor: `div = max(baud_div, MIN_DIV)`, captured in a 32-bit register on start detect. `half = div >> 1`.
- One 32-bit bit-timer and a 3-bit bit index.
- State machine:
  - WAIT_IDLE: entered on reset and after a frame error. Go to IDLE on `rxs == 1`.
  - IDLE: on `rxs == 0`, latch `div`, load timer with `half-1`, go to START.
  - START: when timer expires, sample `rxs`.
    - If 1: false start; go to IDLE, no pulse.
    - Else: load timer with `div-1`, clear bit index, go to DATA.
  - DATA: on each expiry, shift `rxs` into bit [7] of the shift register (LSB first) and reload `div-1`. After bit 7, go to STOP.
  - STOP: on expiry, sample `rxs`.
    - If 1: push the byte, or pulse `overrun` if the FIFO is full and no pop occurs this cycle. Go to IDLE.
    - If 0: pulse `frame_err`, discard the byte, go to WAIT_IDLE.
- FIFO behaviour:
  - Push and pop in the same cycle are both honoured, including when full, so occupancy is unchanged.
  - Pop when empty is ignored.
  - Pointers wrap modulo `FIFO_DEPTH`.
- `rts` is registered and equals `fill < FIFO_DEPTH-1`. One slot is reserved for a character already in flight.
- A `baud_div` change mid-frame has no effect until the next start bit.

## Timing
- Reset values:
  - Outputs: `rts`=0 during reset, then 1 from the first cycle after release; `out_valid`=0, `out_data`=0, `frame_err`=0, `overrun`=0, `fill`=0.
  - Internal: state WAIT_IDLE, synchroniser=1.
- Latency reference point: let t0 be the cycle `rxs` first reads 0 in IDLE.
  - Start sample at t0+half.
  - Data bit i sampled at t0+half+(i+1)·div.
  - Stop sample at t0+half+9·div.
- Push occurs on the stop-sample edge. `out_valid` and `fill` update the following cycle, i.e. stop sample +1.
- Latency from the `rxd` edge adds 2 synchroniser cycles.
- `frame_err` and `overrun` are high for exactly the cycle after the stop sample.
- `rts` follows `fill` with one cycle of delay.
- The next start bit can be detected on the cycle after the STOP sample. Back-to-back characters are therefore received with no idle bit beyond the stop bit.
- Reset mid-frame: all state clears immediately. If `rxd` is still low on release, the block stays in WAIT_IDLE until the line goes high, so no partial byte is produced.

## Test plan
- **Single byte.** `baud_div`=87, send 0xA5 with `out_ready`=1.
  - Required: `out_data`=0xA5 and `out_valid`=1 at t0+43+783+1.
  - `fill` returns to 0 one cycle after the pop.
- **Back-to-back and FIFO fill.** `out_ready`=0, send 0x00, 0xFF, 0x55, 0x3C back-to-back.
  - Required: `rts` drops one cycle after `fill` reaches 3.
  - `fill`=4.
  - Draining returns the bytes in order, and `rts` returns high when `fill`=2.
- **Overrun.** FIFO full (4 entries), `out_ready`=0, send 0x81.
  - Required: one-cycle `overrun`, `fill` stays 4, FIFO contents unchanged.
  - Repeat with `out_ready`=1 on the stop-sample cycle: no `overrun`, 0x81 enters the tail.
- **Framing error and break.**
  - Send 0x12 with stop bit 0: one-cycle `frame_err`, no push.
  - Hold `rxd` low for 20 bit times: no further pulses.
  - After `rxd` returns high, 0x34 is received correctly.
- **Glitch and divisor clamp.**
  - A 10-cycle low pulse with `div`=87 is rejected as a false start: no output.
  - `baud_div`=1 behaves exactly as `div`=4; 0x6E is received.
- **Reset mid-frame.**
  - Assert `reset_n`=0 during bit 3 of 0xC3: all outputs clear asynchronously.
  - Release while `rxd` is low: no byte is produced.
  - A subsequent 0x7A is received correctly.

Source files
------------

// File: rtl/dce_uart_rx.sv
// DCE-side 8N1 UART receiver: bit-timed deserialiser feeding a small byte FIFO,
// with rts throttling so the transactor stops before the buffer overflows.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// WAIT_IDLE | after reset or framing error; wait for the line to read high
// IDLE      | line idle; a low sample marks a start bit
// START     | timing to mid start bit to confirm it is not a glitch
// DATA      | sampling 8 data bits, LSB first
// STOP      | sampling the stop bit; push, overrun or framing error
module dce_uart_rx #(
    parameter int FIFO_DEPTH = 4,
    parameter int MIN_DIV    = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          rxd,
    input  logic [31:0]                   baud_div,
    output logic                          rts,
    output logic                          out_valid,
    output logic [7:0]                    out_data,
    input  logic                          out_ready,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fill
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_F = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] RTS_LIM = (AW+1)'(FIFO_DEPTH - 1);

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rxs;
    logic [1:0]    prime;
    logic [31:0]   div_q;
    logic [31:0]   tmr;
    logic [2:0]    bit_idx;
    logic [7:0]    sr;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic [31:0]   div_eff;
    logic          tc;
    logic          full;
    logic          pop;
    logic          push;

    assign div_eff   = (baud_div < 32'(MIN_DIV)) ? 32'(MIN_DIV) : baud_div;
    assign tc        = (tmr == 32'd0);
    assign full      = (fill == DEPTH_F);
    assign out_valid = (fill != '0);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid & out_ready;
    assign push      = (state == STOP) && tc && rxs && (!full || pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            prime   <= 2'b00;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
            prime   <= {prime[0], 1'b1};
        end
    end

    // prime[1] holds WAIT_IDLE until rxs reflects the real line rather than
    // the synchroniser's reset value, so a reset released mid-low stays put.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= WAIT_IDLE;
            div_q     <= 32'd0;
            tmr       <= 32'd0;
            bit_idx   <= 3'd0;
            sr        <= 8'd0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            case (state)
                WAIT_IDLE: begin
                    if (rxs && prime[1]) state <= IDLE;
                end
                IDLE: begin
                    if (!rxs) begin
                        div_q <= div_eff;
                        tmr   <= (div_eff >> 1) - 32'd1;
                        state <= START;
                    end
                end
                START: begin
                    if (tc) begin
                        if (rxs) begin
                            state <= IDLE;
                        end else begin
                            tmr     <= div_q - 32'd1;
                            bit_idx <= 3'd0;
                            state   <= DATA;
                        end
                    end else begin
                        tmr <= tmr - 32'd1;
                    end
                end
                DATA: begin
                    if (tc) begin
                        sr      <= {rxs, sr[7:1]};
                        tmr     <= div_q - 32'd1;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        tmr <= tmr - 32'd1;
                    end
                end
                STOP: begin
                    if (tc) begin
                        if (rxs) begin
                            if (!push) overrun <= 1'b1;
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
                        end
                    end else begin
                        tmr <= tmr - 32'd1;
                    end
                end
                default: state <= WAIT_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'd0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            rts    <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= sr;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
            // one slot stays free for a character already on the wire
            rts <= (fill < RTS_LIM);
        end
    end

endmodule

// File: tb/tb_dce_uart_rx.sv
// Scoreboard bench for dce_uart_rx: expected bytes queued when frames are
// driven, compared when the consumer side accepts them.
module tb_dce_uart_rx;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        rxd = 1'b1;
    logic [31:0] baud_div = 32'd87;
    logic        out_ready = 1'b0;
    logic        rts;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        frame_err;
    logic        overrun;
    logic [2:0]  fill;

    int          n_chk = 0;
    int          n_pass = 0;
    int          n_pops = 0;
    int          fe_cycles = 0;
    int          ov_cycles = 0;
    int          saved;
    logic [7:0]  exp_q [$];
    logic [7:0]  exp_b;
    logic [7:0]  frame_c3;

    dce_uart_rx #(.FIFO_DEPTH(4), .MIN_DIV(4)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .rxd       (rxd),
        .baud_div  (baud_div),
        .rts       (rts),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .fill      (fill)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive_bit(input logic b, input int n);
        rxd = b;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int n);
        drive_bit(1'b0, n);
        for (int i = 0; i < 8; i++) drive_bit(d[i], n);
        drive_bit(stop, n);
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    // Inputs change on negedges; #1 later they are stable for the next posedge.
    always begin
        @(negedge clock);
        #1;
        if (reset_n) begin
            if (out_valid && out_ready) begin
                n_pops++;
                chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_b = exp_q.pop_front();
                    chk("rx_byte", 32'(out_data), 32'(exp_b));
                end
            end
            if (frame_err) fe_cycles++;
            if (overrun) ov_cycles++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_rts", 32'(rts), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_fill", 32'(fill), 32'd0);
        chk("rst_fe", 32'(frame_err), 32'd0);
        chk("rst_ov", 32'(overrun), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("rts_after_reset", 32'(rts), 32'd1);
        repeat (4) @(negedge clock);

        // single byte, div 87: t0 = fall+2, valid at t0+43+783+1
        baud_div  = 32'd87;
        out_ready = 1'b1;
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1, 87);
            begin
                repeat (828) @(negedge clock);
                chk("t1_valid_early", 32'(out_valid), 32'd0);
                @(negedge clock);
                chk("t1_valid", 32'(out_valid), 32'd1);
                chk("t1_data", 32'(out_data), 32'hA5);
                chk("t1_fill1", 32'(fill), 32'd1);
                @(negedge clock);
                chk("t1_fill0", 32'(fill), 32'd0);
            end
        join
        drive_bit(1'b1, 20);

        // back-to-back fill
        baud_div  = 32'd16;
        out_ready = 1'b0;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h3C);
        fork
            begin
                send_frame(8'h00, 1'b1, 16);
                send_frame(8'hFF, 1'b1, 16);
                send_frame(8'h55, 1'b1, 16);
                send_frame(8'h3C, 1'b1, 16);
            end
            begin
                int k;
                k = 0;
                while (fill != 3'd3 && k < 3000) begin
                    @(negedge clock);
                    k++;
                end
                chk("t2_fill3_seen", 32'(fill), 32'd3);
                chk("t2_rts_at_fill3", 32'(rts), 32'd1);
                @(negedge clock);
                chk("t2_rts_drop", 32'(rts), 32'd0);
            end
        join
        drive_bit(1'b1, 40);
        chk("t2_fill4", 32'(fill), 32'd4);
        chk("t2_rts_full", 32'(rts), 32'd0);
        pop_one();
        chk("t2_fill3", 32'(fill), 32'd3);
        chk("t2_rts_fill3", 32'(rts), 32'd0);
        pop_one();
        chk("t2_fill2", 32'(fill), 32'd2);
        chk("t2_rts_fill2", 32'(rts), 32'd1);
        out_ready = 1'b1;
        repeat (6) @(negedge clock);
        chk("t2_drained", 32'(fill), 32'd0);
        chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // overrun without and with a pop on the stop-sample cycle
        out_ready = 1'b0;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        send_frame(8'h11, 1'b1, 16);
        send_frame(8'h22, 1'b1, 16);
        send_frame(8'h33, 1'b1, 16);
        send_frame(8'h44, 1'b1, 16);
        send_frame(8'h81, 1'b1, 16);
        drive_bit(1'b1, 20);
        chk("t3_ov_pulse", 32'(ov_cycles), 32'd1);
        chk("t3_fill_full", 32'(fill), 32'd4);
        chk("t3_no_fe", 32'(fe_cycles), 32'd0);
        exp_q.push_back(8'h81);
        fork
            send_frame(8'h81, 1'b1, 16);
            begin
                repeat (154) @(negedge clock);
                out_ready = 1'b1;
                @(negedge clock);
                out_ready = 1'b0;
            end
        join
        drive_bit(1'b1, 10);
        chk("t3_ov_none", 32'(ov_cycles), 32'd1);
        chk("t3_fill_still4", 32'(fill), 32'd4);
        out_ready = 1'b1;
        repeat (8) @(negedge clock);
        chk("t3_drained", 32'(fill), 32'd0);
        chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // framing error, then a long break, then a good byte
        send_frame(8'h12, 1'b0, 16);
        drive_bit(1'b0, 20 * 16);
        chk("t4_fe_pulse", 32'(fe_cycles), 32'd1);
        chk("t4_no_push", 32'(fill), 32'd0);
        drive_bit(1'b1, 32);
        exp_q.push_back(8'h34);
        send_frame(8'h34, 1'b1, 16);
        drive_bit(1'b1, 20);
        chk("t4_fe_after_break", 32'(fe_cycles), 32'd1);
        chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        // glitch rejection at div 87
        baud_div = 32'd87;
        saved    = n_pops;
        drive_bit(1'b0, 10);
        drive_bit(1'b1, 200);
        chk("t5_glitch_fill", 32'(fill), 32'd0);
        chk("t5_glitch_no_byte", 32'(n_pops), 32'(saved));
        chk("t5_glitch_no_fe", 32'(fe_cycles), 32'd1);

        // baud_div = 1 clamps to 4: stop sample at fall+40
        baud_div  = 32'd1;
        out_ready = 1'b0;
        exp_q.push_back(8'h6E);
        fork
            send_frame(8'h6E, 1'b1, 4);
            begin
                repeat (40) @(negedge clock);
                chk("t5_clamp_early", 32'(out_valid), 32'd0);
                @(negedge clock);
                chk("t5_clamp_valid", 32'(out_valid), 32'd1);
                chk("t5_clamp_data", 32'(out_data), 32'h6E);
            end
        join
        drive_bit(1'b1, 8);
        out_ready = 1'b1;
        repeat (4) @(negedge clock);
        chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

        // reset in the middle of bit 3 of 0xC3, released while rxd is low
        baud_div  = 32'd16;
        out_ready = 1'b0;
        exp_q.push_back(8'h99);
        send_frame(8'h99, 1'b1, 16);
        drive_bit(1'b1, 16);
        chk("t6_pre_fill", 32'(fill), 32'd1);
        frame_c3 = 8'hC3;
        drive_bit(1'b0, 16);
        for (int i = 0; i < 3; i++) drive_bit(frame_c3[i], 16);
        drive_bit(frame_c3[3], 8);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_fill", 32'(fill), 32'd0);
        chk("t6_rst_data", 32'(out_data), 32'd0);
        chk("t6_rst_rts", 32'(rts), 32'd0);
        exp_q.delete();
        saved = n_pops;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        for (int i = 4; i < 8; i++) drive_bit(frame_c3[i], 16);
        drive_bit(1'b1, 16);
        drive_bit(1'b1, 32);
        chk("t6_no_partial", 32'(fill), 32'd0);
        chk("t6_no_fe", 32'(fe_cycles), 32'd1);
        chk("t6_rts_back", 32'(rts), 32'd1);
        exp_q.push_back(8'h7A);
        out_ready = 1'b1;
        send_frame(8'h7A, 1'b1, 16);
        drive_bit(1'b1, 20);
        chk("t6_one_pop", 32'(n_pops), 32'(saved + 1));
        chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("t6_fill0", 32'(fill), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
